bram_tdp_pipe: RTL and testbench

Single-clock true-dual-port block RAM with configurable byte-lane granularity, read-during-write mode and output pipeline depth. Includes a hardware clear engine that zeroes the array after reset or on request. Used as the shared buffer behind AXI slave and DMA cores when both ports run on one clock.

---
 rtl/bram_tdp_pipe.sv | 167 ++++++++++++++++
 tb/tb_bram_tdp_pipe.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_tdp_pipe.sv
// Single-clock true-dual-port RAM with byte-lane writes, selectable same-port
// read-during-write behaviour, a pipelined read path and a zeroing clear engine.
module bram_tdp_pipe #(
  parameter int    DATA_WIDTH     = 32,
  parameter int    ADDR_WIDTH     = 10,
  parameter int    BYTE_WIDTH     = 8,
  parameter int    RD_LATENCY     = 1,
  parameter string RDW_MODE       = "READ_FIRST",
  parameter int    CLEAR_ON_RESET = 1,
  localparam int   WE_WIDTH       = DATA_WIDTH / BYTE_WIDTH
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  clear_req,
  output logic                  init_busy,
  input  logic                  ena,
  input  logic                  enb,
  input  logic [WE_WIDTH-1:0]   wea,
  input  logic [WE_WIDTH-1:0]   web,
  input  logic [ADDR_WIDTH-1:0] addra,
  input  logic [ADDR_WIDTH-1:0] addrb,
  input  logic [DATA_WIDTH-1:0] dina,
  input  logic [DATA_WIDTH-1:0] dinb,
  output logic [DATA_WIDTH-1:0] douta,
  output logic [DATA_WIDTH-1:0] doutb,
  output logic                  douta_valid,
  output logic                  doutb_valid
);

  localparam int DEPTH       = 2 ** ADDR_WIDTH;
  localparam bit WRITE_FIRST = (RDW_MODE == "WRITE_FIRST");
  localparam bit NO_CHANGE   = (RDW_MODE == "NO_CHANGE");
  localparam bit CLR_ON_RST  = (CLEAR_ON_RESET != 0);

  typedef enum logic [1:0] {IDLE, CLEAR, READY} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_addr_q, clr_addr_d;

  // ---------------------------------------------------------------------------
  // Clear engine
  // ---------------------------------------------------------------------------
  // NOTE: every signal driven here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    case (state_q)
      IDLE: begin
        state_d    = CLR_ON_RST ? CLEAR : READY;
        clr_addr_d = '0;
      end
      CLEAR: begin
        clr_addr_d = clr_addr_q + 1'b1;
        if (&clr_addr_q) state_d = READY;
      end
      READY: begin
        if (clear_req) begin
          state_d    = CLEAR;
          clr_addr_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the values that existed before the edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      clr_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
    end
  end

  // IDLE counts as busy when a clear follows, so no access slips in before it.
  assign init_busy = (state_q == CLEAR) || ((state_q == IDLE) && CLR_ON_RST);

  // ---------------------------------------------------------------------------
  // Port acceptance and read data selection (index 0 = port A, 1 = port B)
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [1:0]            en;
  logic [WE_WIDTH-1:0]   we   [2];
  logic [ADDR_WIDTH-1:0] addr [2];
  logic [DATA_WIDTH-1:0] din  [2];
  logic [1:0]            acc, rd_acc;
  logic [DATA_WIDTH-1:0] rd_word [2];

  assign en      = {enb, ena};
  assign we[0]   = wea;
  assign we[1]   = web;
  assign addr[0] = addra;
  assign addr[1] = addrb;
  assign din[0]  = dina;
  assign din[1]  = dinb;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      acc[p]     = en[p] && !init_busy;
      rd_acc[p]  = acc[p] && !(NO_CHANGE && (|we[p]));
      rd_word[p] = mem[addr[p]];
      // Only the port's own lanes are forwarded; the other port's write is never visible.
      if (WRITE_FIRST) begin
        for (int i = 0; i < WE_WIDTH; i++) begin
          if (we[p][i]) rd_word[p][i*BYTE_WIDTH +: BYTE_WIDTH] = din[p][i*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
    end
  end

  // NOTE: the array has no reset; only the clear engine zeroes it, which keeps
  // it mappable onto block RAM.
  always_ff @(posedge clk) begin
    if (state_q == CLEAR) mem[clr_addr_q] <= '0;
    // Port B is applied first so port A's lanes land last on a shared address.
    for (int p = 1; p >= 0; p--) begin
      if (acc[p]) begin
        for (int i = 0; i < WE_WIDTH; i++) begin
          if (we[p][i]) mem[addr[p]][i*BYTE_WIDTH +: BYTE_WIDTH] <= din[p][i*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read pipeline: stage 0 is the memory read register, later stages only
  // advance data alongside a valid so the output holds between reads.
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] rd_data_q [2][RD_LATENCY];
  logic [DATA_WIDTH-1:0] rd_data_d [2][RD_LATENCY];
  logic [RD_LATENCY-1:0] rd_vld_q  [2];
  logic [RD_LATENCY-1:0] rd_vld_d  [2];

  always_comb begin
    rd_data_d = rd_data_q;
    rd_vld_d  = rd_vld_q;
    for (int p = 0; p < 2; p++) begin
      rd_vld_d[p][0] = rd_acc[p];
      if (rd_acc[p]) rd_data_d[p][0] = rd_word[p];
      for (int s = 1; s < RD_LATENCY; s++) begin
        rd_vld_d[p][s] = rd_vld_q[p][s-1];
        if (rd_vld_q[p][s-1]) rd_data_d[p][s] = rd_data_q[p][s-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_data_q <= '{default: '0};
      rd_vld_q  <= '{default: '0};
    end else begin
      rd_data_q <= rd_data_d;
      rd_vld_q  <= rd_vld_d;
    end
  end

  assign douta       = rd_data_q[0][RD_LATENCY-1];
  assign doutb       = rd_data_q[1][RD_LATENCY-1];
  assign douta_valid = rd_vld_q[0][RD_LATENCY-1];
  assign doutb_valid = rd_vld_q[1][RD_LATENCY-1];

endmodule

// File: tb/tb_bram_tdp_pipe.sv
// Scoreboard bench: three RAM variants (latency/RDW mode) share one stimulus
// stream; a word-array reference model predicts every read and busy window.
module tb_bram_tdp_pipe;

  localparam int DW    = 32;
  localparam int AW    = 4;
  localparam int WEW   = 4;
  localparam int DEPTH = 16;
  localparam int N_DUT = 3;
  localparam int MODE_RF = 0, MODE_WF = 1, MODE_NC = 2;
  localparam int LAT  [N_DUT] = '{1, 3, 2};
  localparam int MODE [N_DUT] = '{MODE_RF, MODE_WF, MODE_NC};

  logic           clk = 1'b0;
  logic           rstn = 1'b0;
  logic           clear_req = 1'b0;
  logic           ena = 1'b0, enb = 1'b0;
  logic [WEW-1:0] wea = '0, web = '0;
  logic [AW-1:0]  addra = '0, addrb = '0;
  logic [DW-1:0]  dina = '0, dinb = '0;

  logic [DW-1:0]  douta_w [N_DUT];
  logic [DW-1:0]  doutb_w [N_DUT];
  logic           douta_valid_w [N_DUT];
  logic           doutb_valid_w [N_DUT];
  logic           init_busy_w [N_DUT];

  always #5 clk = ~clk;

  bram_tdp_pipe #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BYTE_WIDTH(8), .RD_LATENCY(1),
                  .RDW_MODE("READ_FIRST"), .CLEAR_ON_RESET(1)) u_dut0 (
    .clk(clk), .rstn(rstn), .clear_req(clear_req), .init_busy(init_busy_w[0]),
    .ena(ena), .enb(enb), .wea(wea), .web(web), .addra(addra), .addrb(addrb),
    .dina(dina), .dinb(dinb), .douta(douta_w[0]), .doutb(doutb_w[0]),
    .douta_valid(douta_valid_w[0]), .doutb_valid(doutb_valid_w[0]));

  bram_tdp_pipe #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BYTE_WIDTH(8), .RD_LATENCY(3),
                  .RDW_MODE("WRITE_FIRST"), .CLEAR_ON_RESET(1)) u_dut1 (
    .clk(clk), .rstn(rstn), .clear_req(clear_req), .init_busy(init_busy_w[1]),
    .ena(ena), .enb(enb), .wea(wea), .web(web), .addra(addra), .addrb(addrb),
    .dina(dina), .dinb(dinb), .douta(douta_w[1]), .doutb(doutb_w[1]),
    .douta_valid(douta_valid_w[1]), .doutb_valid(doutb_valid_w[1]));

  bram_tdp_pipe #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BYTE_WIDTH(8), .RD_LATENCY(2),
                  .RDW_MODE("NO_CHANGE"), .CLEAR_ON_RESET(1)) u_dut2 (
    .clk(clk), .rstn(rstn), .clear_req(clear_req), .init_busy(init_busy_w[2]),
    .ena(ena), .enb(enb), .wea(wea), .web(web), .addra(addra), .addrb(addrb),
    .dina(dina), .dinb(dinb), .douta(douta_w[2]), .doutb(doutb_w[2]),
    .douta_valid(douta_valid_w[2]), .doutb_valid(doutb_valid_w[2]));

  // Reference model and scoreboard (queue index = 2*dut + port)
  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  logic [DW-1:0] model_mem [DEPTH];
  exp_t          sb_q [2*N_DUT][$];
  logic [DW-1:0] last_q [2*N_DUT];
  int            busy_left = 0;
  int            edge_cnt = 0;
  int            n_pass = 0;
  int            n_total = 0;

  task automatic check(input bit ok, input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] din,
                                          input logic [WEW-1:0] we);
    logic [DW-1:0] r;
    r = old;
    for (int i = 0; i < WEW; i++) if (we[i]) r[i*8 +: 8] = din[i*8 +: 8];
    return r;
  endfunction

  task automatic push_exp(input int k, input logic [DW-1:0] data, input int due);
    exp_t e;
    e.data = data;
    e.due  = due;
    sb_q[k].push_back(e);
  endtask

  // Effect of the current inputs at the edge that has just occurred.
  task automatic model_edge();
    logic [DW-1:0] old_a, old_b;
    edge_cnt++;
    if (rstn) begin
      if (busy_left > 0) begin
        busy_left--;
      end else begin
        old_a = model_mem[addra];
        old_b = model_mem[addrb];
        for (int d = 0; d < N_DUT; d++) begin
          if (ena && !(MODE[d] == MODE_NC && wea != '0))
            push_exp(2*d, (MODE[d] == MODE_WF) ? merge(old_a, dina, wea) : old_a, edge_cnt + LAT[d] - 1);
          if (enb && !(MODE[d] == MODE_NC && web != '0))
            push_exp(2*d+1, (MODE[d] == MODE_WF) ? merge(old_b, dinb, web) : old_b, edge_cnt + LAT[d] - 1);
        end
        if (enb) model_mem[addrb] = merge(model_mem[addrb], dinb, web);
        if (ena) model_mem[addra] = merge(model_mem[addra], dina, wea);
        if (clear_req) begin
          busy_left = DEPTH;
          for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic access(input logic a_en, input logic [WEW-1:0] a_we, input int a_addr, input logic [DW-1:0] a_din,
                        input logic b_en, input logic [WEW-1:0] b_we, input int b_addr, input logic [DW-1:0] b_din);
    ena = a_en; wea = a_we; addra = AW'(a_addr); dina = a_din;
    enb = b_en; web = b_we; addrb = AW'(b_addr); dinb = b_din;
    step();
    ena = 1'b0; enb = 1'b0; wea = '0; web = '0;
  endtask

  task automatic drain();
    repeat (5) step();
  endtask

  task automatic read_all();
    for (int i = 0; i < DEPTH; i++) access(1'b1, '0, i, '0, 1'b1, '0, DEPTH-1-i, '0);
    drain();
  endtask

  task automatic fill_random();
    for (int i = 0; i < DEPTH; i++) access(1'b1, 4'hF, i, $urandom | 32'h1, 1'b0, '0, 0, '0);
    drain();
  endtask

  task automatic assert_reset();
    rstn = 1'b0;
    for (int k = 0; k < 2*N_DUT; k++) begin
      sb_q[k].delete();
      last_q[k] = '0;
    end
    busy_left = 0;
    repeat (2) step();
  endtask

  // Release mid-cycle; the remainder of that cycle is IDLE, the next edge starts the clear.
  task automatic release_reset();
    rstn = 1'b1;
    busy_left = DEPTH + 1;
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    step();
  endtask

  // Counts post-edge cycles with init_busy high while throwing random accesses at the RAM.
  task automatic count_busy(input int pulse_at, output int n);
    n = 0;
    while (init_busy_w[0] && n < 100) begin
      n++;
      ena = 1'($urandom); wea = WEW'($urandom); addra = AW'($urandom); dina = $urandom;
      enb = 1'($urandom); web = WEW'($urandom); addrb = AW'($urandom); dinb = $urandom;
      clear_req = (n == pulse_at);
      step();
    end
    ena = 1'b0; enb = 1'b0; wea = '0; web = '0; clear_req = 1'b0;
  endtask

  // Monitor: sampled on the falling edge, away from the active edge.
  int            mon_k;
  logic [DW-1:0] mon_dout;
  logic          mon_vld;
  logic          mon_ok;
  exp_t          mon_e;
  string         mon_name;

  always @(negedge clk) begin
    for (int d = 0; d < N_DUT; d++) begin
      check(init_busy_w[d] == (!rstn || busy_left > 0), $sformatf("dut%0d_init_busy", d),
            DW'(init_busy_w[d]), DW'(!rstn || busy_left > 0));
      for (int p = 0; p < 2; p++) begin
        mon_k    = 2*d + p;
        mon_dout = (p == 0) ? douta_w[d] : doutb_w[d];
        mon_vld  = (p == 0) ? douta_valid_w[d] : doutb_valid_w[d];
        mon_name = $sformatf("dut%0d_port%s", d, (p == 0) ? "a" : "b");
        if (!rstn) begin
          check(!mon_vld && mon_dout == '0, {mon_name, "_reset"}, mon_dout, '0);
        end else if (mon_vld) begin
          check(sb_q[mon_k].size() > 0, {mon_name, "_spurious_valid"}, DW'(sb_q[mon_k].size()), 32'd1);
          if (sb_q[mon_k].size() > 0) begin
            mon_e = sb_q[mon_k].pop_front();
            check(mon_dout == mon_e.data, {mon_name, "_data"}, mon_dout, mon_e.data);
            check(edge_cnt == mon_e.due, {mon_name, "_latency_edge"}, DW'(edge_cnt), DW'(mon_e.due));
            last_q[mon_k] = mon_e.data;
          end
        end else begin
          check(mon_dout == last_q[mon_k], {mon_name, "_hold"}, mon_dout, last_q[mon_k]);
          if (sb_q[mon_k].size() > 0) begin
            mon_ok = sb_q[mon_k][0].due > edge_cnt;
            check(mon_ok, {mon_name, "_missing_valid"}, DW'(edge_cnt), DW'(sb_q[mon_k][0].due));
            if (!mon_ok) void'(sb_q[mon_k].pop_front());
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n;
    for (int k = 0; k < 2*N_DUT; k++) last_q[k] = '0;

    // Power-up reset and the automatic clear that follows it
    repeat (3) step();
    release_reset();
    count_busy(0, n);
    check(n == DEPTH, "busy_len_power_up", DW'(n), DW'(DEPTH));
    read_all();

    // Byte-lane write
    access(1'b1, 4'hF,    5, 32'h11223344, 1'b0, '0, 0, '0);
    access(1'b1, 4'b0101, 5, 32'hAABBCCDD, 1'b0, '0, 0, '0);
    access(1'b1, 4'h0,    5, '0,           1'b0, '0, 0, '0);
    drain();

    // Same-port read-during-write
    access(1'b1, 4'hF, 2, 32'h00000001, 1'b0, '0, 0, '0);
    drain();
    access(1'b1, 4'hF, 2, 32'h12345678, 1'b0, '0, 0, '0);
    drain();
    access(1'b1, 4'h0, 2, '0,           1'b0, '0, 0, '0);
    drain();

    // Cross-port write collision, then read back on both ports
    access(1'b1, 4'hF,    7, 32'h99887766, 1'b0, '0,      0, '0);
    access(1'b1, 4'b0011, 7, 32'hAAAAAAAA, 1'b1, 4'b0110, 7, 32'hBBBBBBBB);
    access(1'b1, 4'h0,    7, '0,           1'b1, 4'h0,    7, '0);
    drain();

    // Port B reads the address port A writes in the same cycle
    access(1'b1, 4'hF, 3, 32'hCAFEF00D, 1'b0, '0, 0, '0);
    access(1'b1, 4'hF, 3, 32'h01020304, 1'b1, '0, 3, '0);
    access(1'b0, '0,   0, '0,           1'b1, '0, 3, '0);
    drain();

    // Requested clear, with a redundant request pulsed while busy
    fill_random();
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    count_busy(5, n);
    check(n == DEPTH, "busy_len_clear_req", DW'(n), DW'(DEPTH));
    read_all();

    // Reset while the clear counter sits at 9
    fill_random();
    assert_reset();
    release_reset();
    repeat (9) step();
    assert_reset();
    release_reset();
    count_busy(0, n);
    check(n == DEPTH, "busy_len_after_abort", DW'(n), DW'(DEPTH));
    read_all();

    // Randomised traffic, including occasional clear requests
    repeat (400) begin
      ena = 1'($urandom); wea = ($urandom_range(0, 1) == 1) ? WEW'($urandom) : '0;
      addra = AW'($urandom); dina = $urandom;
      enb = 1'($urandom); web = ($urandom_range(0, 1) == 1) ? WEW'($urandom) : '0;
      addrb = AW'($urandom); dinb = $urandom;
      clear_req = ($urandom_range(0, 99) == 0);
      step();
    end
    ena = 1'b0; enb = 1'b0; wea = '0; web = '0; clear_req = 1'b0;
    repeat (DEPTH + 2) step();
    read_all();

    for (int k = 0; k < 2*N_DUT; k++)
      check(sb_q[k].size() == 0, $sformatf("scoreboard_%0d_empty", k), DW'(sb_q[k].size()), '0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
